// File: rtl/ihex_pkg.sv
// Shared types and constants for the Intel-HEX loader.
// Record types, the loader state encoding and the record-length rule.
package ihex_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SYNC,
        S_LEN,
        S_ADDR_HI,
        S_ADDR_LO,
        S_TYPE,
        S_DATA,
        S_CKSUM,
        S_WRITE,
        S_DONE
    } loader_state_t;

    localparam logic [7:0] IHEX_DATA   = 8'h00;
    localparam logic [7:0] IHEX_EOF    = 8'h01;
    localparam logic [7:0] IHEX_ELA    = 8'h04;
    localparam logic [7:0] ASCII_COLON = 8'h3A;

    // A data record carries whole 32-bit words and must fit the buffer.
    function automatic logic len_ok(input logic [7:0] len, input int unsigned max_bytes);
        return (len[1:0] == 2'b00) && (32'(len) <= max_bytes);
    endfunction

endpackage

// File: rtl/ihex_hex_digit.sv
// Combinational ASCII hex-digit decoder: '0'-'9', 'A'-'F', 'a'-'f'.
module ihex_hex_digit (
    input  logic [7:0] ch,
    output logic [3:0] nibble,
    output logic       is_hex
);

    always_comb begin
        nibble = '0;
        is_hex = 1'b0;
        if (ch >= 8'h30 && ch <= 8'h39) begin
            nibble = 4'(ch - 8'h30);
            is_hex = 1'b1;
        end else if (ch >= 8'h41 && ch <= 8'h46) begin
            nibble = 4'(ch - 8'h37);
            is_hex = 1'b1;
        end else if (ch >= 8'h61 && ch <= 8'h66) begin
            nibble = 4'(ch - 8'h57);
            is_hex = 1'b1;
        end
    end

endmodule

// File: rtl/ihex_loader.sv
// Intel-HEX record parser that writes checksum-verified data into RAM via the debug port.
// Optional macro IHEX_EXT_ADDR_EN enables type-04 extended linear address records.
module ihex_loader
    import ihex_pkg::*;
#(
    parameter int unsigned MAX_WORDS = 4,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_override,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_wen,
    input  logic              mem_wait,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       rec_count
);

    localparam int unsigned MAX_BYTES = 4 * MAX_WORDS;
    localparam int unsigned IDX_W     = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

    loader_state_t state;
    logic [3:0]    hi_nib;
    logic          have_hi;
    logic [7:0]    len;
    logic [7:0]    addr_hi;
    logic [7:0]    addr_lo;
    logic [7:0]    rtype;
    logic [7:0]    sum;
    logic [7:0]    byte_cnt;
    logic [5:0]    word_idx;
    logic [15:0]   upper16;
    logic [31:0]   wbuf [MAX_WORDS];

    logic [3:0]    nib;
    logic          is_hex;
    logic          accept;
    logic [7:0]    cur_byte;
    logic [7:0]    sum_next;
    logic [5:0]    word_next;
    logic          last_word;
    logic [31:0]   base_addr;
    logic          len_field_ok;

    ihex_hex_digit u_digit (
        .ch     (rx_data),
        .nibble (nib),
        .is_hex (is_hex)
    );

    assign rx_ready     = (state == S_SYNC)    || (state == S_LEN)   ||
                          (state == S_ADDR_HI) || (state == S_ADDR_LO) ||
                          (state == S_TYPE)    || (state == S_DATA)  ||
                          (state == S_CKSUM);
    assign mem_override = rx_ready || (state == S_WRITE);
    assign busy         = mem_override;

    assign accept    = rx_valid && rx_ready;
    assign cur_byte  = {hi_nib, nib};
    assign sum_next  = sum + cur_byte;
    assign word_next = word_idx + 6'd1;
    assign last_word = (word_next == len[7:2]);
    assign base_addr = {upper16, addr_hi, addr_lo};

`ifdef IHEX_EXT_ADDR_EN
    assign len_field_ok = len_ok(cur_byte, MAX_BYTES) || (cur_byte == 8'd2);
`else
    assign len_field_ok = len_ok(cur_byte, MAX_BYTES);
    assign upper16      = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            hi_nib    <= '0;
            have_hi   <= 1'b0;
            len       <= '0;
            addr_hi   <= '0;
            addr_lo   <= '0;
            rtype     <= '0;
            sum       <= '0;
            byte_cnt  <= '0;
            word_idx  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wen   <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            rec_count <= '0;
`ifdef IHEX_EXT_ADDR_EN
            upper16   <= '0;
`endif
            for (int unsigned i = 0; i < MAX_WORDS; i++) wbuf[i] <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        done      <= 1'b0;
                        error     <= 1'b0;
                        rec_count <= '0;
`ifdef IHEX_EXT_ADDR_EN
                        upper16   <= '0;
`endif
                        state     <= S_SYNC;
                    end
                end

                S_SYNC: begin
                    if (accept && rx_data == ASCII_COLON) begin
                        sum     <= '0;
                        have_hi <= 1'b0;
                        state   <= S_LEN;
                    end
                end

                S_LEN, S_ADDR_HI, S_ADDR_LO, S_TYPE, S_DATA, S_CKSUM: begin
                    if (accept) begin
                        if (!is_hex) begin
                            error <= 1'b1;
                            state <= S_SYNC;
                        end else if (!have_hi) begin
                            hi_nib  <= nib;
                            have_hi <= 1'b1;
                        end else begin
                            // Second nibble completes a byte; dispatch on the field it belongs to.
                            have_hi <= 1'b0;
                            sum     <= sum_next;
                            case (state)
                                S_LEN: begin
                                    len <= cur_byte;
                                    if (len_field_ok) state <= S_ADDR_HI;
                                    else begin
                                        error <= 1'b1;
                                        state <= S_SYNC;
                                    end
                                end
                                S_ADDR_HI: begin
                                    addr_hi <= cur_byte;
                                    state   <= S_ADDR_LO;
                                end
                                S_ADDR_LO: begin
                                    addr_lo <= cur_byte;
                                    if (cur_byte[1:0] == 2'b00) state <= S_TYPE;
                                    else begin
                                        error <= 1'b1;
                                        state <= S_SYNC;
                                    end
                                end
                                S_TYPE: begin
                                    rtype    <= cur_byte;
                                    byte_cnt <= '0;
                                    if (cur_byte == IHEX_DATA && len[1:0] == 2'b00)
                                        state <= (len == 8'd0) ? S_CKSUM : S_DATA;
                                    else if (cur_byte == IHEX_EOF && len == 8'd0)
                                        state <= S_CKSUM;
`ifdef IHEX_EXT_ADDR_EN
                                    else if (cur_byte == IHEX_ELA && len == 8'd2)
                                        state <= S_DATA;
`endif
                                    else begin
                                        error <= 1'b1;
                                        state <= S_SYNC;
                                    end
                                end
                                S_DATA: begin
                                    wbuf[byte_cnt[IDX_W+1:2]] <= {wbuf[byte_cnt[IDX_W+1:2]][23:0], cur_byte};
                                    byte_cnt <= byte_cnt + 8'd1;
                                    if (byte_cnt == len - 8'd1) state <= S_CKSUM;
                                end
                                default: begin
                                    if (sum_next != 8'h00) begin
                                        error <= 1'b1;
                                        state <= S_SYNC;
                                    end else if (rtype == IHEX_DATA) begin
                                        if (len == 8'd0) begin
                                            if (rec_count != 16'hFFFF) rec_count <= rec_count + 16'd1;
                                            state <= S_SYNC;
                                        end else begin
                                            mem_wen   <= 1'b1;
                                            mem_addr  <= ADDR_W'(base_addr);
                                            mem_wdata <= wbuf[0];
                                            word_idx  <= '0;
                                            state     <= S_WRITE;
                                        end
                                    end else if (rtype == IHEX_EOF) begin
                                        done  <= 1'b1;
                                        state <= S_DONE;
                                    end else begin
`ifdef IHEX_EXT_ADDR_EN
                                        upper16 <= wbuf[0][15:0];
`endif
                                        state <= S_SYNC;
                                    end
                                end
                            endcase
                        end
                    end
                end

                S_WRITE: begin
                    if (!mem_wait) begin
                        if (last_word) begin
                            mem_wen <= 1'b0;
                            if (rec_count != 16'hFFFF) rec_count <= rec_count + 16'd1;
                            state   <= S_SYNC;
                        end else begin
                            word_idx  <= word_next;
                            mem_addr  <= mem_addr + ADDR_W'(4);
                            mem_wdata <= wbuf[word_next[IDX_W-1:0]];
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ihex_loader.sv
// Self-checking bench for ihex_loader: scoreboard of expected RAM writes plus a stalling RAM model.
module tb_ihex_loader;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_override;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wen;
    logic        mem_wait;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] rec_count;

    int  checks   = 0;
    int  failures = 0;
    wr_t exp_q[$];
    bit  stall_mode = 1'b0;

    ihex_loader #(.MAX_WORDS(4), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .mem_override (mem_override),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wen      (mem_wen),
        .mem_wait     (mem_wait),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .rec_count    (rec_count)
    );

    always #5 clk = ~clk;

    // RAM model: decides mem_wait for the coming edge and scores completed writes.
    initial begin
        int unsigned stall_cnt;
        logic [31:0] cap_addr, cap_data;
        wr_t         e;
        stall_cnt = 0;
        mem_wait  = 1'b0;
        cap_addr  = '0;
        cap_data  = '0;
        forever begin
            @(negedge clk);
            if (mem_wen === 1'b1) begin
                if (stall_mode && stall_cnt < 3) begin
                    if (stall_cnt == 0) begin
                        cap_addr = mem_addr;
                        cap_data = mem_wdata;
                    end else begin
                        checks++;
                        if (mem_addr !== cap_addr || mem_wdata !== cap_data) begin
                            failures++;
                            $display("FAIL stall_hold: addr=%h data=%h, required addr=%h data=%h",
                                     mem_addr, mem_wdata, cap_addr, cap_data);
                        end
                    end
                    mem_wait = 1'b1;
                    stall_cnt++;
                end else begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_write: addr=%h data=%h, required no write",
                                 mem_addr, mem_wdata);
                    end else begin
                        e = exp_q.pop_front();
                        if (mem_addr !== e.addr || mem_wdata !== e.data) begin
                            failures++;
                            $display("FAIL write: addr=%h data=%h, required addr=%h data=%h",
                                     mem_addr, mem_wdata, e.addr, e.data);
                        end
                    end
                    mem_wait  = 1'b0;
                    stall_cnt = 0;
                end
            end else begin
                mem_wait  = 1'b0;
                stall_cnt = 0;
            end
        end
    end

    task automatic send_char(input logic [7:0] c);
        int unsigned n = 0;
        @(negedge clk);
        rx_data  = c;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (rx_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL rx_timeout: rx_ready=%b, required 1 within 500 cycles", rx_ready);
        end
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int unsigned n = 0;
        while ((exp_q.size() != 0 || mem_wen === 1'b1) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: pending=%0d, required 0", tag, exp_q.size());
        end
    endtask

    task automatic finish_eof(input string tag, input logic exp_err, input logic [15:0] exp_cnt);
        send_str(":00000001FF");
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || error !== exp_err || rec_count !== exp_cnt) begin
            failures++;
            $display("FAIL %s_status: done=%b error=%b rec_count=%0d, required done=1 error=%b rec_count=%0d",
                     tag, done, error, rec_count, exp_err, exp_cnt);
        end
        checks++;
        if (mem_override !== 1'b0 || busy !== 1'b0 || rx_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle: override=%b busy=%b rx_ready=%b, required 0 0 0",
                     tag, mem_override, busy, rx_ready);
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({rx_ready, mem_override, mem_wen, busy, done, error} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl: rdy/ovr/wen/busy/done/err=%b, required 000000",
                     {rx_ready, mem_override, mem_wen, busy, done, error});
        end
        checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || rec_count !== 16'h0) begin
            failures++;
            $display("FAIL reset_data: addr=%h data=%h rec_count=%h, required all 0",
                     mem_addr, mem_wdata, rec_count);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        pulse_start();
        checks++;
        if (busy !== 1'b1 || mem_override !== 1'b1 || rx_ready !== 1'b1) begin
            failures++;
            $display("FAIL start_state: busy=%b override=%b rx_ready=%b, required 1 1 1",
                     busy, mem_override, rx_ready);
        end
        exp_q.push_back('{addr: 32'h0000_0008, data: 32'hDEADBEEF});
        send_str(":04000800DEADBEEFBC");
        checks++;
        if (mem_wen !== 1'b1) begin
            failures++;
            $display("FAIL first_wen_latency: mem_wen=%b, required 1", mem_wen);
        end
        wait_drain("basic");
        finish_eof("basic", 1'b0, 16'd1);
    endtask

    task automatic test_bad_checksum();
        pulse_start();
        exp_q.push_back('{addr: 32'h0000_0008, data: 32'hDEADBEEF});
        send_str(":04000800DEADBEEFBD");
        @(negedge clk);
        checks++;
        if (error !== 1'b1 || mem_wen !== 1'b0) begin
            failures++;
            $display("FAIL bad_cksum: error=%b mem_wen=%b, required 1 0", error, mem_wen);
        end
        send_str(":04000800deadbeefBC");
        wait_drain("lower");
        finish_eof("lower", 1'b1, 16'd1);
    endtask

    task automatic test_stall();
        pulse_start();
        stall_mode = 1'b1;
        exp_q.push_back('{addr: 32'h0000_0010, data: 32'h11111111});
        exp_q.push_back('{addr: 32'h0000_0014, data: 32'h22222222});
        send_str(":0800100011111111222222221C");
        wait_drain("stall");
        stall_mode = 1'b0;
        finish_eof("stall", 1'b0, 16'd1);
    endtask

    task automatic test_bad_fields();
        pulse_start();
        send_str(":140000000000\r\n");
        send_str(":04000200DEADBEEFC2\r\n");
        @(negedge clk);
        checks++;
        if (error !== 1'b1 || rec_count !== 16'd0) begin
            failures++;
            $display("FAIL bad_fields: error=%b rec_count=%0d, required 1 0", error, rec_count);
        end
        exp_q.push_back('{addr: 32'h0000_000C, data: 32'hCAFEF00D});
        send_str(":04000C00CAFEF00D2B\r\n");
        wait_drain("resync");
        finish_eof("resync", 1'b1, 16'd1);
    endtask

    task automatic test_ext_addr();
        logic [31:0] exp_addr;
        logic        exp_err;
`ifdef IHEX_EXT_ADDR_EN
        exp_addr = 32'h0001_0008;
        exp_err  = 1'b0;
`else
        exp_addr = 32'h0000_0008;
        exp_err  = 1'b1;
`endif
        pulse_start();
        send_str(":020000040001F9");
        exp_q.push_back('{addr: exp_addr, data: 32'hDEADBEEF});
        send_str(":04000800DEADBEEFBC");
        wait_drain("ela");
        finish_eof("ela", exp_err, 16'd1);
    endtask

    task automatic test_reset_mid_write();
        pulse_start();
        stall_mode = 1'b1;
        exp_q.push_back('{addr: 32'h0000_0008, data: 32'hDEADBEEF});
        send_str(":04000800DEADBEEFBC");
        checks++;
        if (mem_wen !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_wen: mem_wen=%b, required 1", mem_wen);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({mem_wen, rx_ready, mem_override, busy, done, error} !== 6'b0 ||
            rec_count !== 16'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            failures++;
            $display("FAIL async_reset: wen/rdy/ovr/busy/done/err=%b addr=%h data=%h cnt=%0d, required all 0",
                     {mem_wen, rx_ready, mem_override, busy, done, error}, mem_addr, mem_wdata, rec_count);
        end
        exp_q.delete();
        @(negedge clk);
        rst        = 1'b0;
        stall_mode = 1'b0;
        @(negedge clk);
        pulse_start();
        exp_q.push_back('{addr: 32'h0000_0008, data: 32'hDEADBEEF});
        send_str(":04000800DEADBEEFBC");
        wait_drain("resend");
        finish_eof("resend", 1'b0, 16'd1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_checksum();
        test_stall();
        test_bad_fields();
        test_ext_addr();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ihex_loader.md
Name: ihex_loader

Overview:
- Hardware Intel-HEX ingest engine; the load-side counterpart of the debug RAM dump, which emits one ":04AAAA00DDDDDDDDCC" record per non-zero word and ends with ":00000001FF".
- Consumes an ASCII byte stream from the UART RX path and parses records.
- Buffers each record and verifies its checksum, then writes the words into CPU RAM through the debug/override port while the core is held off.
- Lets the test harness preload programs, or restore a dump, without simulator file I/O.

Parameters:
MAX_WORDS, 4, maximum 32-bit data words per record (buffer depth; record length limit = 4*MAX_WORDS bytes)
ADDR_W, 32, RAM byte-address width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; arms the loader from IDLE or DONE
rx_data  in  8  ASCII byte from the UART receiver
rx_valid  in  1  rx_data valid
rx_ready  out  1  loader accepts a byte this cycle (a byte transfers when rx_valid && rx_ready)
mem_override  out  1  take control of the RAM debug port; high from start until DONE
mem_addr  out  ADDR_W  word-aligned write byte address
mem_wdata  out  32  write data
mem_wen  out  1  write request
mem_wait  in  1  RAM busy; a write completes in the first cycle with mem_wen && !mem_wait
busy  out  1  loader active (any state except IDLE and DONE)
done  out  1  sticky; a valid EOF record was received
error  out  1  sticky; at least one record was rejected
rec_count  out  16  count of data records committed; saturates at 0xFFFF

Behaviour:
- Async reset: state=IDLE. rx_ready, mem_override, mem_wen, busy, done and error are 0. mem_addr, mem_wdata, rec_count, the upper-address register and the buffer are all 0. Reset mid-write drops mem_wen immediately; a partial record is discarded.
- start accepted only in IDLE/DONE: clears done, error, rec_count and the upper-address register; goes to SYNC. start while busy is ignored.
- Character rules: '0'-'9', 'A'-'F' and 'a'-'f' are hex digits; pairs combine high nibble first into one byte. In SYNC every character except ':' is dropped. Any other non-hex character inside a record is an error.
- States: IDLE -> SYNC (wait ':') -> LEN -> ADDR_HI -> ADDR_LO -> TYPE -> DATA (LEN bytes; skipped when LEN=0) -> CKSUM -> WRITE (record type 00 only) -> SYNC. A type-01 record goes to DONE.
- Running checksum: 8-bit sum of every byte including the checksum byte. A record is valid only if the sum is 0x00.
- Validation, checked at the field where the violation becomes known:
  - LEN must be a multiple of 4 and at most 4*MAX_WORDS.
  - The address must be aligned to 4.
  - Type must be 00 or 01; 04 is also allowed when the optional feature is enabled.
  - Type 01 requires LEN=0.
  - Any violation: set error, discard the record, go to SYNC. Nothing is written.
- Data packing: each 4 bytes form one word, most-significant byte first, so "DEADBEEF" gives 0xDEADBEEF. Word k goes to address {upper16, AAAA} + 4*k.
- rx_ready is 1 in SYNC through CKSUM and 0 in IDLE, WRITE and DONE.
- WRITE: drive the buffered words one at a time in increasing k.
  - mem_addr, mem_wdata and mem_wen stay stable while mem_wait=1.
  - On completion, advance to the next word in the following cycle. One word per cycle is possible when mem_wait=0.
  - After the last word, rec_count is incremented and the FSM returns to SYNC.
- DONE: done=1, mem_override=0, busy=0. Incoming bytes are not accepted.
- mem_override=1 in every state from SYNC through WRITE.
- Latency: the first mem_wen is asserted in the cycle after the checksum byte is accepted.

Optional Feature:
- Macro: IHEX_EXT_ADDR_EN
- Defined: type 04 (extended linear address) is accepted.
  - It requires LEN=2; the data field is loaded into upper16 after checksum verification.
  - No RAM write occurs. rec_count is unchanged.
- Undefined: upper16 is constant 0 and a type-04 record is an error.

Decomposition:
- Shared package ihex_pkg holds:
  - the loader_state_t enum;
  - record-type constants IHEX_DATA=8'h00, IHEX_EOF=8'h01, IHEX_ELA=8'h04;
  - ASCII_COLON=8'h3A.
- One natural sub-module, ihex_hex_digit: a combinational ASCII-to-nibble decoder with outputs nibble[3:0] and is_hex.

Test Plan:
- start, ":04000800DEADBEEFBC", ":00000001FF" -> one write, addr 0x8, data 0xDEADBEEF; rec_count=1; done=1; error=0; mem_override falls after EOF.
- ":04000800DEADBEEFBD" (bad checksum), then a valid ":04000800deadbeefBC" -> first record: no write, error=1. Second record: written (lowercase accepted), rec_count=1.
- ":0800100011111111222222221C" with mem_wait high for 3 cycles per word -> writes 0x10<-0x11111111, then 0x14<-0x22222222. mem_addr, mem_wdata and mem_wen are held stable throughout each stall.
- Record with LEN=0x14 (exceeds 4*MAX_WORDS) or address 0x0002 -> no write, error=1; the loader resyncs on the next ':'. CR/LF between records is ignored.
- With IHEX_EXT_ADDR_EN: ":020000040001F9" then ":04000800DEADBEEFBC" -> write to 0x00010008. Without the macro: the first record raises error, and the second writes to 0x00000008.
- Assert rst during WRITE -> mem_wen=0 asynchronously; all outputs return to reset values. start plus a full resend completes normally.
